// File: rtl/gate3_chk_pkg.sv
// gate3_chk_pkg: shared types and constants for the 3-input cell checker.
//   - state_t      : checker FSM states
//   - VEC_COUNT    : number of input vectors per sweep
//   - *_TT         : truth tables, bit i = expected y for {c,b,a} == i
//   - GRAY_MAP     : step -> vector table for the low-power Gray-order sweep
//                    (used when GATE3_CHK_GRAY_EN is defined)
package gate3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int         VEC_COUNT = 8;
  localparam logic [2:0] LAST_STEP = 3'd7;
  localparam logic [2:0] VEC_FIRST = 3'b000;

  localparam logic [7:0] NAND3_TT = 8'h7F;
  localparam logic [7:0] NOR3_TT  = 8'h01;
  localparam logic [7:0] AND3_TT  = 8'h80;

  // Entry k (bits 3k+2..3k) is the vector applied at step k: 0,1,3,2,6,7,5,4.
  localparam logic [23:0] GRAY_MAP = {3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};

  function automatic logic [2:0] gray_of_step(input logic [2:0] step);
    return GRAY_MAP[int'(step) * 3 +: 3];
  endfunction

endpackage

// File: rtl/gate3_vec_seq.sv
// gate3_vec_seq: step counter and step -> vector mapping for one sweep.
// Order is binary 0..7 by default, Gray 0,1,3,2,6,7,5,4 when the macro
// GATE3_CHK_GRAY_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : return to step 0 (new sweep accepted)
//   adv       : advance one step (end of a hold window)
//   next_vec  : vector for the step after the current one
//   last      : current step is the final one of the sweep
module gate3_vec_seq
  import gate3_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] next_vec,
  output logic       last
);

  logic [2:0] step_r;
  logic [2:0] step_nxt_s;

  function automatic logic [2:0] map_step(input logic [2:0] step);
`ifdef GATE3_CHK_GRAY_EN
    return gray_of_step(step);
`else
    return step;
`endif
  endfunction

  // Step counter: cleared on a new sweep, advanced once per hold window.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r <= 3'd0;
    end else if (clr) begin
      step_r <= 3'd0;
    end else if (adv) begin
      step_r <= step_nxt_s;
    end else begin
      step_r <= step_r;
    end
  end

  // Next-step vector and last-step flag.
  always_comb begin
    step_nxt_s = step_r + 3'd1;
    next_vec   = map_step(step_nxt_s);
    last       = (step_r == LAST_STEP);
  end

endmodule

// File: rtl/gate3_stim_checker.sv
// gate3_stim_checker: sweeps a 3-input cell through all 8 input vectors,
// samples its output at the end of each hold window and compares it against
// the FUNC truth table. Define GATE3_CHK_GRAY_EN for a Gray-order sweep.
// Parameters:
//   HOLD_CYCLES : cycles each vector is held (>= 2)
//   FUNC        : expected truth table, bit i = y for {c,b,a} == i
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : sweep request, honoured only in IDLE
//   dut_y       : output of the cell under test
//   a, b, c     : cell inputs (vector bits 0, 1, 2)
//   busy        : sweep in progress
//   done        : one-cycle pulse at sweep completion
//   pass        : last completed sweep had no mismatches
//   err_count   : mismatching vectors in the last/current sweep
//   fail_vec    : bit i set when vector i mismatched
module gate3_stim_checker
  import gate3_chk_pkg::*;
#(
  parameter int         HOLD_CYCLES = 200,
  parameter logic [7:0] FUNC        = NAND3_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  localparam int             CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 2);

  state_t           state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [2:0]       cba_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [3:0]       err_count_r;
  logic [7:0]       fail_vec_r;

  logic             seq_clr_s;
  logic             seq_adv_s;
  logic [2:0]       seq_next_vec_s;
  logic             seq_last_s;
  logic             mismatch_s;
  logic [3:0]       err_next_s;
  logic [7:0]       fail_set_s;

  gate3_vec_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (seq_clr_s),
    .adv      (seq_adv_s),
    .next_vec (seq_next_vec_s),
    .last     (seq_last_s)
  );

  // Sequencer control and compare of the currently applied vector.
  // Indexing by the applied {c,b,a} keeps FUNC/fail_vec order-independent.
  always_comb begin
    seq_clr_s  = (state_r == IDLE) && start;
    seq_adv_s  = (state_r == SAMPLE) && !seq_last_s;
    mismatch_s = (dut_y != FUNC[cba_r]);
    err_next_s = err_count_r + {3'b000, mismatch_s};
    fail_set_s = mismatch_s ? (8'h01 << cba_r) : 8'h00;
  end

  // Checker FSM with hold counter, vector drive and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_cnt_r  <= '0;
      cba_r       <= 3'b000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= 4'd0;
      fail_vec_r  <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= APPLY;
            hold_cnt_r  <= '0;
            cba_r       <= VEC_FIRST;
            busy_r      <= 1'b1;
            pass_r      <= 1'b0;
            err_count_r <= 4'd0;
            fail_vec_r  <= 8'h00;
          end else begin
            state_r <= IDLE;
          end
        end
        // Counting to HOLD_CYCLES-2 plus the SAMPLE cycle gives HOLD_CYCLES per vector.
        APPLY: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r    <= SAMPLE;
            hold_cnt_r <= '0;
          end else begin
            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        SAMPLE: begin
          err_count_r <= err_next_s;
          fail_vec_r  <= fail_vec_r | fail_set_s;
          if (seq_last_s) begin
            // Results, done and idle drive all appear in the DONE cycle.
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            cba_r   <= 3'b000;
            pass_r  <= (err_next_s == 4'd0);
          end else begin
            state_r <= APPLY;
            cba_r   <= seq_next_vec_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign a         = cba_r[0];
  assign b         = cba_r[1];
  assign c         = cba_r[2];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_count_r;
  assign fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_gate3_stim_checker.sv
// tb_gate3_stim_checker: directed bench for gate3_stim_checker with
// HOLD_CYCLES=4 and the default NAND3 truth table. dut_y comes from an ideal
// NAND3, a stuck-at-1 or a stuck-at-0 model. Define GATE3_CHK_GRAY_EN to
// expect the Gray-order sweep.
module tb_gate3_stim_checker;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_y;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  int n_total = 0;
  int n_pass  = 0;
  int mode    = 0;  // 0 ideal NAND3, 1 stuck-at-1, 2 stuck-at-0

  logic [2:0] exp_order [8];
  int         exp_toggles;

  assign dut_y = (mode == 0) ? ~(a & b & c) : (mode == 1);

  always #5 clk = ~clk;

  gate3_stim_checker #(.HOLD_CYCLES(HOLD), .FUNC(8'h7F)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_y     (dut_y),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {14'd0, a, b, c, busy, done, pass, err_count, fail_vec}, 32'd0);
  endtask

  // One sweep; start re-pulsed in cycle `glitch` (0 = never). Cycle k is
  // sampled on the k-th falling edge after the start edge.
  task automatic sweep(input int glitch, input string tag);
    int         done_at;
    int         done_cnt;
    int         toggles;
    logic [2:0] prev;
    logic [2:0] cur;
    done_at  = 0;
    done_cnt = 0;
    toggles  = 0;
    prev     = 3'b000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      start = (k == glitch);
      cur = {c, b, a};
      if (k <= 32) begin
        check($sformatf("%s_vec_c%0d", tag, k), {29'd0, cur}, {29'd0, exp_order[(k - 1) / HOLD]});
        toggles += $countones(cur ^ prev);
        prev = cur;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == 33) check({tag, "_idle_drive"}, {28'd0, busy, c, b, a}, 32'd0);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_at, 33);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_toggles"}, toggles, exp_toggles);
  endtask

  task automatic check_results(input string tag, input logic p, input logic [3:0] e, input logic [7:0] f);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    check({tag, "_err_count"}, {28'd0, err_count}, {28'd0, e});
    check({tag, "_fail_vec"}, {24'd0, fail_vec}, {24'd0, f});
  endtask

  initial begin
    int done_seen;
`ifdef GATE3_CHK_GRAY_EN
    exp_order   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    exp_toggles = 7;
`else
    exp_order   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_toggles = 11;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Ideal NAND3.
    mode = 0;
    sweep(0, "ideal");
    check_results("ideal", 1'b1, 4'd0, 8'h00);

    // Stuck-at-1: only vector 7 (expected 0) mismatches.
    mode = 1;
    sweep(0, "stuck1");
    check_results("stuck1", 1'b0, 4'd1, 8'h80);

    // Stuck-at-0: vectors 0..6 (expected 1) mismatch.
    mode = 2;
    sweep(0, "stuck0");
    check_results("stuck0", 1'b0, 4'd7, 8'h7F);
    repeat (5) @(negedge clk);
    check_results("stuck0_hold", 1'b0, 4'd7, 8'h7F);

    // Start while busy (cycle 5, after vector 0 already failed) is ignored.
    sweep(5, "glitch");
    check_results("glitch", 1'b0, 4'd7, 8'h7F);

    // Reset in cycle 10 of a sweep.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst_zero");
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    sweep(0, "after_rst");
    check_results("after_rst", 1'b1, 4'd0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
